shift_normalizer: RTL and testbench
===================================

SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter: n, default 31, MSB index of the data path (width n+1).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  request a new count; sampled only in IDLE.
REQ-006 Port: in  input  n+1  operand; sampled together with start.
REQ-007 Port: count_ones  input  1  mode: 0 = count leading zeros (CLZ), 1 = count leading ones (CLO); sampled with start.
REQ-008 Port: busy  output  1  high while an operation is in progress (SHIFT or DONE state).
REQ-009 Port: done  output  1  one-cycle pulse marking valid out/cnt.
REQ-010 Port: out  output  n+1  operand shifted left by cnt, zero-filled.
REQ-011 Port: cnt  output  6  leading-bit count, range 0..n+1 (0..32 at default).

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; busy, done, out and cnt SHALL all be registered.
REQ-013 IDLE: on a rising edge with start=1, the block SHALL latch in into a working register, latch count_ones, clear the internal counter and enter SHIFT.
REQ-014 The target bit SHALL be 0 for CLZ and 1 for CLO.
REQ-015 SHIFT, each edge: if the working MSB differs from the target bit, or the counter equals n+1, the block SHALL enter DONE; otherwise it SHALL shift the working register left by 1 (LSB := 0) and increment the counter.
REQ-016 On the edge entering DONE, out SHALL load the working register, cnt SHALL load the counter and done SHALL go to 1.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE with done=0.
REQ-018 Latency: for a result count k, done SHALL be high in the cycle following the (k+1)-th rising edge after the start-sampling edge (k=0 gives 1 edge; k=32 gives 33 edges).
REQ-019 out and cnt SHALL hold their values from DONE until the next DONE or reset.
REQ-020 start SHALL be ignored in SHIFT and DONE, so no queuing occurs; in, count_ones and the working register SHALL not be disturbed.
REQ-021 If start is held high continuously, a new operation SHALL be accepted on the first IDLE edge after DONE, giving one idle cycle between operations.
REQ-022 An all-zero operand in CLZ, or an all-ones operand in CLO, SHALL yield cnt = n+1 and out = 0.
REQ-023 The counter SHALL never exceed n+1, and no wrap-around SHALL occur.

Reset
REQ-024 While rst=1, independent of clk, the block SHALL force state=IDLE, busy=0, done=0, out=0, cnt=0, and clear the working register and counter.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be handled normally.

Verification
REQ-026 CLZ, in=0x0000_0001 -> done 32 edges after start; cnt=31, out=0x8000_0000; busy high from the edge after start through the DONE cycle.
REQ-027 CLZ, in=0x8000_0000 -> done 1 edge after start; cnt=0, out=0x8000_0000.
REQ-028 CLZ, in=0x0000_0000 -> done 33 edges after start; cnt=32, out=0x0000_0000.
REQ-029 CLO, in=0xF0F0_0000 -> cnt=4, out=0x0F00_0000; CLO, in=0xFFFF_FFFF -> cnt=32, out=0.
REQ-030 CLZ, in=0x0001_0000, then start with in=0xFFFF_FFFF pulsed during SHIFT -> ignored; result cnt=15, out=0x8000_0000; start held high -> second operation accepted one cycle after done.
REQ-031 rst pulsed asynchronously (between clock edges) mid-SHIFT -> busy, done, out, cnt go to 0 immediately with no done pulse; a subsequent start with in=0x0000_00FF, CLZ -> cnt=24, out=0xFF00_0000.

Source files
------------

// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative leading-zero / leading-one counter.
// The operand is shifted left one bit per clock until its MSB differs
// from the target bit or the whole word has been consumed. The block then
// presents the normalised word on out, the number of shifts on cnt, and a
// one-cycle done pulse.
module shift_normalizer #(
  parameter int n = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [n:0] in,
  input  logic       count_ones,
  output logic       busy,
  output logic       done,
  output logic [n:0] out,
  output logic [5:0] cnt
);

  // Counter saturates at the full word width; cnt is 6 bits, so n+1 <= 63.
  localparam logic [5:0] LIMIT = 6'(n + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [n:0] work;
  logic [n:0] work_nxt;
  logic [5:0] count;
  logic [5:0] count_nxt;
  logic       mode;
  logic       mode_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic [n:0] out_nxt;
  logic [5:0] cnt_nxt;

  // Scan terminates once the MSB no longer matches the target bit or the
  // counter has reached the word width (all bits matched).
  function automatic logic scan_end(input logic msb, input logic target,
                                    input logic [5:0] c);
    return (msb != target) || (c == LIMIT);
  endfunction

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    count_nxt = count;
    mode_nxt  = mode;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    out_nxt   = out;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          work_nxt  = in;
          mode_nxt  = count_ones;
          count_nxt = 6'd0;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy_nxt = 1'b1;
        if (scan_end(work[n], mode, count)) begin
          out_nxt   = work;
          cnt_nxt   = count;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          work_nxt  = {work[n-1:0], 1'b0};
          count_nxt = count + 6'd1;
        end
      end
      DONE: begin
        // start is ignored here; the next request is taken from IDLE.
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Working register, counter, mode and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work  <= '0;
      count <= 6'd0;
      mode  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      cnt   <= 6'd0;
    end else begin
      work  <= work_nxt;
      count <= count_nxt;
      mode  <= mode_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      out   <= out_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: directed and randomized checks of shift_normalizer
// against a plain-arithmetic leading-bit count model.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in = '0;
  logic        count_ones = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [5:0]  cnt;

  int checks = 0;
  int errors = 0;

  shift_normalizer #(.n(31)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .count_ones(count_ones),
    .busy(busy), .done(done), .out(out), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: count leading bits equal to the target, then shift.
  function automatic int ref_k(input logic [31:0] v, input bit m);
    int k = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i] == m) k++;
      else break;
    end
    return k;
  endfunction

  function automatic logic [31:0] ref_out(input logic [31:0] v, input bit m);
    int k = ref_k(v, m);
    return (k >= 32) ? 32'h0 : (v << k);
  endfunction

  // Present a request so it is sampled on the next rising edge.
  task automatic kick(input logic [31:0] v, input bit m, input bit hold);
    start = 1'b1;
    in = v;
    count_ones = m;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Count edges since the start edge until done, then check the result.
  task automatic finish_op(input string tag, input logic [31:0] v, input bit m,
                           input int edges0);
    int k = ref_k(v, m);
    int e = edges0;
    bit seen = 1'b0;
    while (e < 40 && !seen) begin
      @(posedge clk);
      #1;
      e++;
      if (done) seen = 1'b1;
      else chk($sformatf("%s busy_run", tag), busy, 1'b1);
    end
    chk($sformatf("%s done_seen", tag), seen, 1'b1);
    chk($sformatf("%s latency", tag), e, k + 1);
    chk($sformatf("%s cnt", tag), cnt, k);
    chk($sformatf("%s out", tag), out, ref_out(v, m));
    chk($sformatf("%s busy_done", tag), busy, 1'b1);
    @(posedge clk);
    #1;
    chk($sformatf("%s done_pulse", tag), done, 1'b0);
    chk($sformatf("%s busy_idle", tag), busy, 1'b0);
    chk($sformatf("%s out_hold", tag), out, ref_out(v, m));
    chk($sformatf("%s cnt_hold", tag), cnt, k);
  endtask

  initial begin
    logic [31:0] v;
    bit m;
    int sh;
    bit dseen;

    // Reset state
    #12;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst out", out, 32'h0);
    chk("rst cnt", cnt, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corner cases
    kick(32'h0000_0001, 1'b0, 1'b0);
    chk("clz1 busy_start", busy, 1'b1);
    finish_op("clz1", 32'h0000_0001, 1'b0, 0);
    kick(32'h8000_0000, 1'b0, 1'b0);
    finish_op("clz_msb", 32'h8000_0000, 1'b0, 0);
    kick(32'h0000_0000, 1'b0, 1'b0);
    finish_op("clz_zero", 32'h0000_0000, 1'b0, 0);
    kick(32'hF0F0_0000, 1'b1, 1'b0);
    finish_op("clo_f0", 32'hF0F0_0000, 1'b1, 0);
    kick(32'hFFFF_FFFF, 1'b1, 1'b0);
    finish_op("clo_ones", 32'hFFFF_FFFF, 1'b1, 0);

    // start pulsed mid-operation must be ignored
    kick(32'h0001_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; in = 32'hFFFF_FFFF; count_ones = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in = 32'h0; count_ones = 1'b0;
    finish_op("ign", 32'h0001_0000, 1'b0, 3);

    // start held high: next operation accepted after one idle cycle
    kick(32'h00F0_0000, 1'b0, 1'b1);
    finish_op("hold1", 32'h00F0_0000, 1'b0, 0);
    @(posedge clk); #1;
    chk("hold accept busy", busy, 1'b1);
    start = 1'b0;
    finish_op("hold2", 32'h00F0_0000, 1'b0, 0);

    // Asynchronous reset mid-SHIFT
    kick(32'h0000_0001, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #3;
    rst = 1'b1;
    #1;
    chk("arst busy", busy, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst out", out, 32'h0);
    chk("arst cnt", cnt, 6'd0);
    #1;
    rst = 1'b0;
    dseen = 1'b0;
    repeat (36) begin
      @(posedge clk); #1;
      if (done || busy) dseen = 1'b1;
    end
    chk("arst no_done", dseen, 1'b0);
    kick(32'h0000_00FF, 1'b0, 1'b0);
    finish_op("post_rst", 32'h0000_00FF, 1'b0, 0);

    // Randomized operands covering every count
    for (int i = 0; i < 40; i++) begin
      sh = $urandom_range(0, 32);
      v = $urandom;
      v = (sh >= 32) ? 32'h0 : (v >> sh);
      if (sh < 32) v[31 - sh] = 1'b1;
      if ($urandom_range(0, 3) == 0) v = $urandom;
      m = 1'($urandom_range(0, 1));
      if (m) v = ~v;
      kick(v, m, 1'b0);
      finish_op($sformatf("rnd%0d", i), v, m, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
